ccip_tx_write_shaper: RTL



---
 rtl/ccip_tx_write_shaper.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/ccip_tx_write_shaper.sv
// CCI-P c1 write shaper: buffers write lines, releases each multi-CL batch atomically,
// and throttles on platform almost-full and an in-flight write-line credit limit.
module ccip_tx_write_shaper #(
  parameter int unsigned NIC_ID          = 0,
  parameter int unsigned LBUF_DEPTH      = 4,
  parameter int unsigned MAX_OUTSTANDING = 64,
  localparam int unsigned OutW           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  // Transmitter-side write requests
  input  logic                  tx_in_valid_i,
  input  logic [1:0]            tx_in_vc_sel_i,
  input  logic                  tx_in_sop_i,
  input  logic [1:0]            tx_in_cl_len_i,
  input  logic [3:0]            tx_in_req_type_i,
  input  logic [41:0]           tx_in_address_i,
  input  logic [15:0]           tx_in_mdata_i,
  input  logic [511:0]          tx_in_data_i,
  output logic                  tx_in_almost_full_o,
  // Platform c1 flow control and responses
  input  logic                  s_rx_c1_tx_alm_full_i,
  input  logic                  s_rx_c1_rsp_valid_i,
  input  logic [3:0]            s_rx_c1_resp_type_i,
  input  logic                  s_rx_c1_format_i,
  input  logic [1:0]            s_rx_c1_cl_num_i,
  // Platform-side write requests
  output logic                  s_tx_c1_valid_o,
  output logic [1:0]            s_tx_c1_vc_sel_o,
  output logic                  s_tx_c1_sop_o,
  output logic [1:0]            s_tx_c1_cl_len_o,
  output logic [3:0]            s_tx_c1_req_type_o,
  output logic [41:0]           s_tx_c1_address_o,
  output logic [15:0]           s_tx_c1_mdata_o,
  output logic [511:0]          s_tx_c1_data_o,
  // Statistics
  output logic [OutW-1:0]       outstanding_o,
  output logic [LBUF_DEPTH:0]   occupancy_o,
  output logic [31:0]           drop_cnt_o,
  output logic                  error_o
);

  localparam int unsigned Entries  = 1 << LBUF_DEPTH;
  localparam int unsigned EntW     = 2 + 1 + 2 + 4 + 42 + 16 + 512;
  localparam int unsigned SumW     = OutW + 3;
  localparam logic [3:0]  RspWrline = 4'h1;

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StBurst = 1'b1;

  // Instance number is only meaningful to simulation tracing.
  logic unused_nic_id;
  assign unused_nic_id = ^NIC_ID;

  logic [EntW-1:0]       mem_q [Entries];
  logic [LBUF_DEPTH-1:0] wr_ptr_q, rd_ptr_q;
  logic [LBUF_DEPTH:0]   count_q, count_d;
  logic [0:0]            state_q, state_d;
  logic [1:0]            rem_q, rem_d;
  logic [OutW-1:0]       out_q, out_d;
  logic [31:0]           drop_q;
  logic                  error_q;
  logic                  tx_valid_q;
  logic [EntW-1:0]       tx_ent_q;

  logic [EntW-1:0] in_ent, head;
  logic [1:0]      h_vc_sel, h_cl_len;
  logic            h_sop;
  logic [3:0]      h_req_type;
  logic [41:0]     h_addr;
  logic [15:0]     h_mdata;
  logic [511:0]    h_data;

  logic            fifo_empty, fifo_full, push, pop, drop;
  logic            drive, proto_err, underflow, credit_ok;
  logic [2:0]      n, issue_n, dec;
  logic [SumW-1:0] out_sum;

  assign in_ent = {tx_in_vc_sel_i, tx_in_sop_i, tx_in_cl_len_i, tx_in_req_type_i,
                   tx_in_address_i, tx_in_mdata_i, tx_in_data_i};
  assign head = mem_q[rd_ptr_q];
  assign {h_vc_sel, h_sop, h_cl_len, h_req_type, h_addr, h_mdata, h_data} = head;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == (LBUF_DEPTH + 1)'(Entries));
  assign n          = {1'b0, h_cl_len} + 3'd1;
  assign credit_ok  = (SumW'(out_q) + SumW'(n)) <= SumW'(MAX_OUTSTANDING);

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    pop       = 1'b0;
    drive     = 1'b0;
    issue_n   = 3'd0;
    proto_err = 1'b0;
    case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          if (!h_sop) begin
            // Orphan continuation line: discard it so the queue cannot wedge.
            pop       = 1'b1;
            proto_err = 1'b1;
          end else if (count_q >= (LBUF_DEPTH + 1)'(n) && !s_rx_c1_tx_alm_full_i &&
                       credit_ok) begin
            pop     = 1'b1;
            drive   = 1'b1;
            issue_n = n;
            rem_d   = h_cl_len;
            if (h_cl_len != 2'd0) state_d = StBurst;
          end
        end
      end
      StBurst: begin
        if (!s_rx_c1_tx_alm_full_i && !fifo_empty) begin
          pop   = 1'b1;
          drive = 1'b1;
          if (h_sop) proto_err = 1'b1;
          rem_d = rem_q - 2'd1;
          if (rem_q == 2'd1) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign push    = tx_in_valid_i && (!fifo_full || pop);
  assign drop    = tx_in_valid_i && fifo_full && !pop;
  assign count_d = count_q + (LBUF_DEPTH + 1)'(push) - (LBUF_DEPTH + 1)'(pop);

  // Issue and write-line response in the same cycle apply as one net change.
  always_comb begin
    dec = 3'd0;
    if (s_rx_c1_rsp_valid_i && s_rx_c1_resp_type_i == RspWrline) begin
      dec = s_rx_c1_format_i ? ({1'b0, s_rx_c1_cl_num_i} + 3'd1) : 3'd1;
    end
    out_sum   = SumW'(out_q) + SumW'(issue_n);
    underflow = SumW'(dec) > out_sum;
    out_d     = underflow ? '0 : OutW'(out_sum - SumW'(dec));
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_ent;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      rem_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      out_q      <= '0;
      drop_q     <= '0;
      error_q    <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_ent_q   <= '0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      count_q    <= count_d;
      out_q      <= out_d;
      tx_valid_q <= drive;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (drive) tx_ent_q <= head;
      if (drop && drop_q != 32'hFFFF_FFFF) drop_q <= drop_q + 32'd1;
      error_q <= error_q | drop | proto_err | underflow;
    end
  end

  assign {s_tx_c1_vc_sel_o, s_tx_c1_sop_o, s_tx_c1_cl_len_o, s_tx_c1_req_type_o,
          s_tx_c1_address_o, s_tx_c1_mdata_o, s_tx_c1_data_o} = tx_ent_q;
  assign s_tx_c1_valid_o     = tx_valid_q;
  assign outstanding_o       = out_q;
  assign occupancy_o         = count_q;
  assign drop_cnt_o          = drop_q;
  assign error_o             = error_q;
  // Free entries <= 4 keeps room for one maximum-size batch.
  assign tx_in_almost_full_o = count_q >= (LBUF_DEPTH + 1)'(Entries - 4);

endmodule
